// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles every non-clock/reset signal of alu_op_sequencer.
//   Request side : in_valid, in_ready, in_command, in_A, in_B
//   ALU side     : alu_A, alu_B, alu_command (to ALU), alu_result (from ALU)
//   Result side  : out_valid, out_ready, out_result, out_zero, out_error, out_command
//   modport slave  : the sequencer's view
//   modport master : the surrounding environment's view (requester, ALU, consumer)
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_command;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [2:0]       alu_command;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_error;
  logic [2:0]       out_command;

  modport slave (
    input  in_valid, in_command, in_A, in_B, alu_result, out_ready,
    output in_ready, alu_A, alu_B, alu_command,
           out_valid, out_result, out_zero, out_error, out_command
  );

  modport master (
    output in_valid, in_command, in_A, in_B, alu_result, out_ready,
    input  in_ready, alu_A, alu_B, alu_command,
           out_valid, out_result, out_zero, out_error, out_command
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue stage in front of a combinational ALU. Requests {command, A, B}
//   are queued in a DEPTH-entry FIFO, driven onto the ALU from registers,
//   held for SETTLE cycles, then the result is captured into an output
//   register and offered with a valid/ready handshake. Illegal requests
//   (opcode 7, DIV/MOD with B < 2) bypass the ALU and return an error
//   result of all ones.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : alu_op_sequencer_if.slave (request, ALU and result signals)
//   ops_done, errs_done : handshake counters, only with ALU_SEQ_STATS_EN
// Optional feature macro: ALU_SEQ_STATS_EN
module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       ops_done,
  output logic [15:0]       errs_done
`endif
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int SETW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t           state, state_next;
  logic [2:0]       fifo_cmd [DEPTH];
  logic [WIDTH-1:0] fifo_a   [DEPTH];
  logic [WIDTH-1:0] fifo_b   [DEPTH];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;
  logic [SETW-1:0]  settle_cnt;
  logic             full, empty, push, pop;
  logic             load_alu, load_err, capture, release_out;
  logic [2:0]       head_cmd;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_illegal;

  assign full         = (count == CNTW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  assign head_cmd = fifo_cmd[rd_ptr];
  assign head_a   = fifo_a[rd_ptr];
  assign head_b   = fifo_b[rd_ptr];
  // B of 0 or 1 is rejected for DIV/MOD, so only bits above bit 0 matter.
  assign head_illegal = (head_cmd == 3'd7) ||
                        (((head_cmd == 3'd5) || (head_cmd == 3'd6)) &&
                         (head_b[WIDTH-1:1] == '0));

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr] <= bus.in_command;
      fifo_a[wr_ptr]   <= bus.in_A;
      fifo_b[wr_ptr]   <= bus.in_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // HOLD with out_ready applies the same pop rules as IDLE in the same edge,
  // so back-to-back results need no idle cycle between handshakes.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    load_alu    = 1'b0;
    load_err    = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            load_err   = 1'b1;
            state_next = HOLD;
          end else begin
            load_alu   = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (settle_cnt == SETW'(1)) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          if (empty) begin
            state_next = IDLE;
          end else begin
            pop = 1'b1;
            if (head_illegal) begin
              load_err   = 1'b1;
              state_next = HOLD;
            end else begin
              load_alu   = 1'b1;
              state_next = DRIVE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh result (capture or error load) takes priority over clearing
  // out_valid, which lets an error follow a handshake without a gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_A       <= '0;
      bus.alu_B       <= '0;
      bus.alu_command <= '0;
      settle_cnt      <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_zero    <= 1'b0;
      bus.out_error   <= 1'b0;
      bus.out_command <= '0;
    end else begin
      if (load_alu) begin
        bus.alu_A       <= head_a;
        bus.alu_B       <= head_b;
        bus.alu_command <= head_cmd;
        settle_cnt      <= SETW'(SETTLE);
      end else if (state == DRIVE) begin
        settle_cnt <= settle_cnt - SETW'(1);
      end
      if (capture) begin
        bus.out_result  <= bus.alu_result;
        bus.out_zero    <= (bus.alu_result == '0);
        bus.out_error   <= 1'b0;
        bus.out_command <= bus.alu_command;
        bus.out_valid   <= 1'b1;
      end else if (load_err) begin
        bus.out_result  <= '1;
        bus.out_zero    <= 1'b0;
        bus.out_error   <= 1'b1;
        bus.out_command <= head_cmd;
        bus.out_valid   <= 1'b1;
      end else if (release_out) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating handshake counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_done  <= '0;
      errs_done <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
      if (bus.out_error && (errs_done != 16'hFFFF)) errs_done <= errs_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Scoreboard bench for alu_op_sequencer. Accepted requests push the
//   reference-model response into a queue; a monitor pops and compares on
//   every result handshake. A behavioural ALU answers the DUT's alu_* lines.
//   Build with ALU_SEQ_STATS_EN to also cover the handshake counters.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        error;
    logic [2:0]  command;
  } exp_t;

  logic clk;
  logic reset;
  alu_op_sequencer_if #(.WIDTH(16)) bus ();
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] ops_done, errs_done;
`endif

  alu_op_sequencer #(.WIDTH(16), .DEPTH(4), .SETTLE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef ALU_SEQ_STATS_EN
    ,
    .ops_done  (ops_done),
    .errs_done (errs_done)
`endif
  );

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   hs_edges[$];
  bit   rdy_fixed = 1'b1;
  bit   rdy_rand  = 1'b0;
  int   acc_edge;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_f(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a;
      3'd4: return b;
      3'd5: return (b == 0) ? 16'hFFFF : a / b;
      3'd6: return (b == 0) ? a : a % b;
      default: return 16'h0000;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_command, bus.alu_A, bus.alu_B);

  function automatic exp_t ref_model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.command = c;
    if (c == 3'd7 || ((c == 3'd5 || c == 3'd6) && b < 16'd2)) begin
      e.result = 16'hFFFF;
      e.zero   = 1'b0;
      e.error  = 1'b1;
    end else begin
      e.result = alu_f(c, a, b);
      e.zero   = (e.result == 16'h0000);
      e.error  = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Consumer-ready driver; lands 2 time units after the edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor / scoreboard: everything sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready)
        sb.push_back(ref_model(bus.in_command, bus.in_A, bus.in_B));
      if (bus.out_valid && bus.out_ready) begin
        hs_edges.push_back(cyc + 1);
        if (sb.size() == 0) begin
          checkOutput(1'b0, "unexpected_result", 32'(bus.out_result), 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput(bus.out_result == e.result, "out_result", 32'(bus.out_result), 32'(e.result));
          checkOutput(bus.out_zero == e.zero, "out_zero", 32'(bus.out_zero), 32'(e.zero));
          checkOutput(bus.out_error == e.error, "out_error", 32'(bus.out_error), 32'(e.error));
          checkOutput(bus.out_command == e.command, "out_command", 32'(bus.out_command), 32'(e.command));
        end
      end
    end
  end

  task automatic driveReq(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid   = 1'b1;
    bus.in_command = c;
    bus.in_A       = a;
    bus.in_B       = b;
  endtask

  // Drives a request after the next edge and waits for the negedge that
  // guarantees acceptance; in_valid stays high so sends can run back to back.
  task automatic applyStimulus(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    driveReq(c, a, b);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    acc_edge = cyc + 1;
    if (!got) checkOutput(1'b0, "accept_timeout", 32'(bus.in_ready), 32'h1);
  endtask

  task automatic idleIn();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    if (!done) checkOutput(1'b0, "drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic checkLatency(input string name, input int expect_edge);
    bit seen = 1'b0;
    int at = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    checkOutput(seen && at == expect_edge, name, 32'(at), 32'(expect_edge));
  endtask

  task automatic randReq(input bit legal_only, output logic [2:0] c, output logic [15:0] a, output logic [15:0] b);
    c = legal_only ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
    a = 16'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
  endtask

  initial begin
    logic [2:0]  c;
    logic [15:0] a, b;
    int n_acc, held_bad, stale;
    bit got;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_command = '0;
    bus.in_A = '0;
    bus.in_B = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(bus.in_ready == 1'b1, "rst_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput(bus.alu_A == 16'h0, "rst_alu_A", 32'(bus.alu_A), 32'h0);
    checkOutput(bus.alu_B == 16'h0, "rst_alu_B", 32'(bus.alu_B), 32'h0);
    checkOutput(bus.alu_command == 3'h0, "rst_alu_command", 32'(bus.alu_command), 32'h0);
    checkOutput(bus.out_result == 16'h0, "rst_out_result", 32'(bus.out_result), 32'h0);
    checkOutput({bus.out_zero, bus.out_error} == 2'b00, "rst_out_flags", 32'({bus.out_zero, bus.out_error}), 32'h0);
    checkOutput(bus.out_command == 3'h0, "rst_out_command", 32'(bus.out_command), 32'h0);
    reset = 1'b0;

    // Legal latency: accepted at T, visible after T+1+SETTLE.
    applyStimulus(3'd0, 16'h0006, 16'h0004);
    idleIn();
    checkLatency("add_latency", acc_edge + 3);
    drain();

    applyStimulus(3'd1, 16'h0010, 16'h0010);
    idleIn();
    drain();

    // Illegal requests: visible after T+1, ALU registers untouched.
    applyStimulus(3'd5, 16'h1234, 16'h0001);
    idleIn();
    checkLatency("illegal_latency", acc_edge + 1);
    drain();
    applyStimulus(3'd7, 16'hABCD, 16'h0005);
    idleIn();
    drain();
    checkOutput(bus.alu_command == 3'd1, "alu_cmd_kept", 32'(bus.alu_command), 32'h1);
    checkOutput(bus.alu_A == 16'h0010, "alu_A_kept", 32'(bus.alu_A), 32'h10);

    // Backpressure: one request in flight plus DEPTH queued, then stall.
    rdy_fixed = 1'b0;
    @(posedge clk);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      randReq(1'b1, c, a, b);
      driveReq(c, a, b);
      @(negedge clk);
      if (!bus.in_ready) break;
      n_acc++;
    end
    checkOutput(n_acc == 5, "burst_accepted", 32'(n_acc), 32'd5);
    held_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.in_ready) held_bad++;
    end
    checkOutput(held_bad == 0, "held_off", 32'(held_bad), 32'h0);
    hs_edges.delete();
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    checkOutput(got, "pending_accepted", 32'(got), 32'h1);
    idleIn();
    drain();
    checkOutput(hs_edges.size() == 6, "burst_results", 32'(hs_edges.size()), 32'd6);
    if (hs_edges.size() == 6)
      for (int k = 1; k < 6; k++)
        checkOutput(hs_edges[k] - hs_edges[k-1] == 3, "burst_spacing",
                    32'(hs_edges[k] - hs_edges[k-1]), 32'd3);

    // Reset while DRIVE with two requests queued.
    rdy_fixed = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      randReq(1'b1, c, a, b);
      applyStimulus(c, a, b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput(bus.out_valid == 1'b0, "midrst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput(bus.in_ready == 1'b1, "midrst_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_fixed = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checkOutput(stale == 0, "no_stale_results", 32'(stale), 32'h0);

    // Randomized traffic with random consumer backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      randReq(1'b0, c, a, b);
      applyStimulus(c, a, b);
      if ($urandom_range(0, 2) == 0) idleIn();
    end
    idleIn();
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    drain();

`ifdef ALU_SEQ_STATS_EN
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(3'd0, 16'h0001, 16'h0002);
    applyStimulus(3'd6, 16'h0009, 16'h0000);
    applyStimulus(3'd2, 16'h00F0, 16'h0F0F);
    applyStimulus(3'd7, 16'h0000, 16'h0000);
    applyStimulus(3'd5, 16'h0064, 16'h0005);
    idleIn();
    drain();
    @(posedge clk);
    #1;
    checkOutput(ops_done == 16'd5, "ops_done", 32'(ops_done), 32'd5);
    checkOutput(errs_done == 16'd2, "errs_done", 32'(errs_done), 32'd2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
